imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/imem_fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Instruction fetch controller for a fixed-latency instruction memory.
// A fetch address is held on imem_addr for WAIT_CYCLES cycles. The returned
// word is then captured into a single IF/ID output register. If that register
// is still occupied and stalled, the controller parks in WAIT_DS with the
// address held. It loads the word as soon as the register frees up.
// A redirect flushes everything and restarts fetch at the (word-aligned)
// target address.
//
// Ports
//   clk            : clock, rising edge
//   reset          : synchronous active-high reset, highest priority
//   stall          : hazard hold on the IF/ID register
//   redirect_valid : taken branch/jump, flush and restart at redirect_pc
//   redirect_pc    : byte address of the redirect target
//   imem_rdata     : combinational read data from the instruction memory
//   imem_addr      : byte address to the instruction memory (fetch_pc)
//   if_valid       : if_instr/if_pc hold an unconsumed instruction
//   if_instr       : fetched instruction word
//   if_pc          : byte address of if_instr
//   fetch_err      : sticky misaligned-redirect / out-of-range flag
// ---------------------------------------------------------------------------
module imem_fetch_ctrl #(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_WORDS  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_err
);

    localparam logic [0:0]  S_FETCH   = 1'b0;
    localparam logic [0:0]  S_WAIT_DS = 1'b1;

    localparam logic [3:0]  WAIT_LAST  = 4'(WAIT_CYCLES - 1);
    localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

    logic [0:0]  state_reg;
    logic [3:0]  wait_cnt_reg;
    logic [31:0] fetch_pc_reg;
    logic        if_valid_reg;
    logic [31:0] if_instr_reg;
    logic [31:0] if_pc_reg;
    logic        fetch_err_reg;

    logic accept;
    logic wait_done;
    logic load;
    logic out_of_range;

    // The output register can take a word when it is empty or being consumed.
    assign accept       = !if_valid_reg || !stall;
    assign wait_done    = (wait_cnt_reg == WAIT_LAST);
    // In WAIT_DS the access is already complete; only acceptance is missing.
    assign load         = accept && ((state_reg == S_WAIT_DS) ||
                                     ((state_reg == S_FETCH) && wait_done));
    assign out_of_range = (fetch_pc_reg[31:2] >= IMEM_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_FETCH;
            wait_cnt_reg  <= 4'd0;
            fetch_pc_reg  <= RESET_PC;
            if_valid_reg  <= 1'b0;
            if_instr_reg  <= 32'h0;
            if_pc_reg     <= 32'h0;
            fetch_err_reg <= 1'b0;
        end else if (redirect_valid) begin
            // Any access completing this cycle is dropped.
            state_reg    <= S_FETCH;
            wait_cnt_reg <= 4'd0;
            fetch_pc_reg <= {redirect_pc[31:2], 2'b00};
            if_valid_reg <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                fetch_err_reg <= 1'b1;
            end
        end else if (load) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= 4'd0;
            fetch_pc_reg <= fetch_pc_reg + 32'd4;
            if_valid_reg <= 1'b1;
            if_pc_reg    <= fetch_pc_reg;
            // Fetches past the end of memory deliver a NOP and flag the error.
            if (out_of_range) begin
                if_instr_reg  <= 32'h0000_0000;
                fetch_err_reg <= 1'b1;
            end else begin
                if_instr_reg  <= imem_rdata;
            end
        end else begin
            if (state_reg == S_FETCH) begin
                if (wait_done) begin
                    // Complete but blocked: park with the address held.
                    state_reg <= S_WAIT_DS;
                end else begin
                    wait_cnt_reg <= wait_cnt_reg + 4'd1;
                end
            end
            if (if_valid_reg && !stall) begin
                if_valid_reg <= 1'b0;
            end
        end
    end

    assign imem_addr = fetch_pc_reg;
    assign if_valid  = if_valid_reg;
    assign if_instr  = if_instr_reg;
    assign if_pc     = if_pc_reg;
    assign fetch_err = fetch_err_reg;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//
// Directed bench for imem_fetch_ctrl. Two instances share the control inputs:
// dut1 uses WAIT_CYCLES=1 and dut3 uses WAIT_CYCLES=3. Each DUT has its own
// memory model. Word i of the model holds 32'hC0DE_0000 + i. Out-of-range
// addresses read as 32'hDEAD_BEEF, so that NOP substitution is visible.
// ---------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic [31:0] rdata1, addr1, instr1, pc1;
    logic        valid1, err1;
    logic [31:0] rdata3, addr3, instr3, pc3;
    logic        valid3, err3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr[31:2] < 30'd1024) return 32'hC0DE_0000 + {2'b00, addr[31:2]};
        else                       return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] w(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    assign rdata1 = mem_word(addr1);
    assign rdata3 = mem_word(addr3);

    imem_fetch_ctrl #(.WAIT_CYCLES(1), .RESET_PC(32'h0), .IMEM_WORDS(1024)) dut1 (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_rdata(rdata1), .imem_addr(addr1), .if_valid(valid1),
        .if_instr(instr1), .if_pc(pc1), .fetch_err(err1)
    );

    imem_fetch_ctrl #(.WAIT_CYCLES(3), .RESET_PC(32'h0), .IMEM_WORDS(1024)) dut3 (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_rdata(rdata3), .imem_addr(addr3), .if_valid(valid3),
        .if_instr(instr3), .if_pc(pc3), .fetch_err(err3)
    );

    // Advance one rising edge; outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        step();
        step();
        checks++;
        if (addr1 !== 32'h0 || valid1 !== 1'b0 || instr1 !== 32'h0 ||
            pc1 !== 32'h0 || err1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_dut1 addr=%h valid=%b instr=%h pc=%h err=%b exp 0/0/0/0/0",
                     addr1, valid1, instr1, pc1, err1);
        end
        checks++;
        if (dut1.state_reg !== 1'b0 || dut1.wait_cnt_reg !== 4'd0) begin
            failures++;
            $display("FAIL reset_state state=%b wait_cnt=%0d exp 0/0",
                     dut1.state_reg, dut1.wait_cnt_reg);
        end
        checks++;
        if (addr3 !== 32'h0 || valid3 !== 1'b0 || err3 !== 1'b0) begin
            failures++;
            $display("FAIL reset_dut3 addr=%h valid=%b err=%b exp 0/0/0", addr3, valid3, err3);
        end
        $display("reset: addr=%h valid=%b instr=%h pc=%h err=%b", addr1, valid1, instr1, pc1, err1);
        reset = 1'b0;
    endtask

    task automatic test_stream();
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (valid1 !== 1'b1 || pc1 !== 32'(4 * i) || instr1 !== w(i)) begin
                failures++;
                $display("FAIL stream_%0d valid=%b pc=%h instr=%h exp 1/%h/%h",
                         i, valid1, pc1, instr1, 32'(4 * i), w(i));
            end
            $display("stream cycle %0d: pc=%h instr=%h", i + 1, pc1, instr1);
        end
    endtask

    task automatic test_wait3();
        logic        exp_v;
        logic [31:0] exp_a;
        pulse_reset();
        for (int k = 1; k <= 9; k++) begin
            step();
            exp_v = (k % 3 == 0);
            exp_a = 32'(4 * (k / 3));
            checks++;
            if (valid3 !== exp_v || addr3 !== exp_a) begin
                failures++;
                $display("FAIL wait3_cycle%0d valid=%b addr=%h exp %b/%h",
                         k, valid3, addr3, exp_v, exp_a);
            end
            if (exp_v) begin
                checks++;
                if (pc3 !== 32'(4 * (k / 3 - 1)) || instr3 !== w(k / 3 - 1)) begin
                    failures++;
                    $display("FAIL wait3_word%0d pc=%h instr=%h exp %h/%h",
                             k, pc3, instr3, 32'(4 * (k / 3 - 1)), w(k / 3 - 1));
                end
            end
            $display("wait3 cycle %0d: valid=%b addr=%h pc=%h", k, valid3, addr3, pc3);
        end
    endtask

    // Scenarios 3, 4 and 5 run back to back from one reset on dut1.
    task automatic test_stall_redirect();
        pulse_reset();
        step(); step(); step();           // pc 0, 4, 8 delivered
        stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (valid1 !== 1'b1 || pc1 !== 32'h8 || instr1 !== w(2) ||
                addr1 !== 32'hC || dut1.state_reg !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold%0d valid=%b pc=%h instr=%h addr=%h state=%b exp 1/8/%h/c/1",
                         c, valid1, pc1, instr1, addr1, dut1.state_reg, w(2));
            end
            $display("stall cycle %0d: pc=%h addr=%h state=%b", c, pc1, addr1, dut1.state_reg);
        end
        stall = 1'b0;
        step();
        checks++;
        if (valid1 !== 1'b1 || pc1 !== 32'hC || instr1 !== w(3) || addr1 !== 32'h10) begin
            failures++;
            $display("FAIL stall_release valid=%b pc=%h instr=%h addr=%h exp 1/c/%h/10",
                     valid1, pc1, instr1, addr1, w(3));
        end
        $display("stall release: pc=%h instr=%h", pc1, instr1);

        // Redirect coincides with completion at fetch_pc=16.
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (valid1 !== 1'b0 || addr1 !== 32'h40 || pc1 !== 32'hC || err1 !== 1'b0) begin
            failures++;
            $display("FAIL redirect_flush valid=%b addr=%h pc=%h err=%b exp 0/40/c/0",
                     valid1, addr1, pc1, err1);
        end
        step();
        checks++;
        if (valid1 !== 1'b1 || pc1 !== 32'h40 || instr1 !== w(16)) begin
            failures++;
            $display("FAIL redirect_target valid=%b pc=%h instr=%h exp 1/40/%h",
                     valid1, pc1, instr1, w(16));
        end
        $display("redirect 0x40: pc=%h instr=%h", pc1, instr1);

        // Misaligned redirect.
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (err1 !== 1'b1 || valid1 !== 1'b0 || addr1 !== 32'h40) begin
            failures++;
            $display("FAIL misalign err=%b valid=%b addr=%h exp 1/0/40", err1, valid1, addr1);
        end
        step();
        checks++;
        if (valid1 !== 1'b1 || pc1 !== 32'h40 || instr1 !== w(16) || err1 !== 1'b1) begin
            failures++;
            $display("FAIL misalign_word valid=%b pc=%h instr=%h err=%b exp 1/40/%h/1",
                     valid1, pc1, instr1, err1, w(16));
        end
        $display("redirect 0x42: pc=%h err=%b", pc1, err1);

        // Out-of-range fetch.
        redirect_valid = 1'b1; redirect_pc = 32'h1000;
        step();
        redirect_valid = 1'b0;
        step();
        checks++;
        if (valid1 !== 1'b1 || pc1 !== 32'h1000 || instr1 !== 32'h0 || err1 !== 1'b1) begin
            failures++;
            $display("FAIL out_of_range valid=%b pc=%h instr=%h err=%b exp 1/1000/0/1",
                     valid1, pc1, instr1, err1);
        end
        $display("redirect 0x1000: pc=%h instr=%h err=%b", pc1, instr1, err1);
    endtask

    // Continues from test_stall_redirect: dut1 holds pc 0x1000 with fetch_pc 0x1004.
    task automatic test_reset_in_wait_ds();
        stall = 1'b1;
        step();
        checks++;
        if (dut1.state_reg !== 1'b1 || addr1 !== 32'h1004) begin
            failures++;
            $display("FAIL enter_wait_ds state=%b addr=%h exp 1/1004", dut1.state_reg, addr1);
        end
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        step();
        reset = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
        checks++;
        if (addr1 !== 32'h0 || valid1 !== 1'b0 || instr1 !== 32'h0 || pc1 !== 32'h0 ||
            err1 !== 1'b0 || dut1.state_reg !== 1'b0) begin
            failures++;
            $display("FAIL reset_wait_ds addr=%h valid=%b instr=%h pc=%h err=%b state=%b exp all 0",
                     addr1, valid1, instr1, pc1, err1, dut1.state_reg);
        end
        step();
        checks++;
        if (valid1 !== 1'b1 || pc1 !== 32'h0 || instr1 !== w(0)) begin
            failures++;
            $display("FAIL after_reset valid=%b pc=%h instr=%h exp 1/0/%h",
                     valid1, pc1, instr1, w(0));
        end
        $display("reset in WAIT_DS: next pc=%h instr=%h", pc1, instr1);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wait3();
        test_stall_redirect();
        test_reset_in_wait_ds();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
